// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-symbol sampling FSM and a
// single-entry ready/valid output register with framing-error and overrun pulses.
module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       framing_error,
    output logic       overrun
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CW               = $clog2(SYMBOL_EDGE_TIME) + 1;
    localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CW-1:0] MID_LAST = CW'(SAMPLE_TIME - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          byte_done;

    logic mid_hit, sym_hit, sample_bit, stop_ok, stop_bad, xfer;

    // Control strobes decoded from the current state and counter
    always_comb begin
        mid_hit    = (state == START) && (cnt == MID_LAST);
        sym_hit    = ((state == DATA) || (state == STOP)) && (cnt == SYM_LAST);
        sample_bit = sym_hit && (state == DATA);
        stop_ok    = sym_hit && (state == STOP) && rx_s;
        stop_bad   = sym_hit && (state == STOP) && !rx_s;
        xfer       = data_out_valid && data_out_ready;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (armed && !rx_s) state_nxt = START;
            START: if (mid_hit) state_nxt = rx_s ? IDLE : DATA;
            DATA:  if (sample_bit && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:  if (sym_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rx_m           <= 1'b1;
            rx_s           <= 1'b1;
            armed          <= 1'b0;
            cnt            <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            byte_done      <= 1'b0;
            framing_error  <= 1'b0;
            overrun        <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            rx_m  <= serial_in;
            rx_s  <= rx_m;

            unique case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!armed && rx_s) armed <= 1'b1;
                end
                START: begin
                    cnt <= mid_hit ? '0 : cnt + 1'b1;
                    if (mid_hit) bit_idx <= '0;
                end
                DATA: begin
                    if (sample_bit) begin
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 1'b1;
                        cnt            <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    cnt <= sym_hit ? '0 : cnt + 1'b1;
                    // A low stop bit means the line may be stuck low; wait for high
                    if (stop_bad) armed <= 1'b0;
                end
                default: cnt <= '0;
            endcase

            // shreg is untouched until the next frame's first data sample
            byte_done     <= stop_ok;
            framing_error <= stop_bad;
            overrun       <= 1'b0;

            if (byte_done) begin
                if (!data_out_valid || xfer) begin
                    data_out       <= shreg;
                    data_out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 1000 Hz / 100 baud (10 cycles per symbol).
module tb_uart_receiver;
    localparam int CF  = 1000;
    localparam int BR  = 100;
    localparam int SYM = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    int         xcnt   = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic [7:0] xlog [0:63];

    always #5 clk = ~clk;

    uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .framing_error  (framing_error),
        .overrun        (overrun)
    );

    // Inputs change just after posedge, so negedge sees what the next posedge will
    always @(negedge clk) begin
        if (!reset) begin
            if (data_out_valid && data_out_ready) begin
                xlog[xcnt[5:0]] <= data_out;
                xcnt <= xcnt + 1;
            end
            if (framing_error) fe_cnt <= fe_cnt + 1;
            if (overrun)       ov_cnt <= ov_cnt + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        tick(SYM);
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            tick(SYM);
        end
        serial_in = stop;
        tick(SYM);
    endtask

    task automatic test_reset();
        int n;
        logic found;
        reset = 1'b1; serial_in = 1'b1; data_out_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        total++; if (data_out !== 8'h00)     begin bad++; $display("FAIL reset_data got=%h want=00", data_out); end
        total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", data_out_valid); end
        total++; if (framing_error !== 1'b0)  begin bad++; $display("FAIL reset_fe got=%b want=0", framing_error); end
        total++; if (overrun !== 1'b0)        begin bad++; $display("FAIL reset_ov got=%b want=0", overrun); end
        tick(5);
        n = 0; found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            for (int i = 1; i <= 200 && !found; i++) begin
                @(posedge clk); #2;
                if (data_out_valid) begin found = 1'b1; n = i; end
            end
        join
        total++; if (n != 99)           begin bad++; $display("FAIL first_latency got=%0d want=99", n); end
        total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL first_data got=%h want=a5", data_out); end
    endtask

    task automatic test_back_to_back();
        int b, fb, ob;
        data_out_ready = 1'b1;
        tick(2);
        b = xcnt; fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        tick(20);
        total++; if (xcnt - b != 3)      begin bad++; $display("FAIL b2b_count got=%0d want=3", xcnt - b); end
        total++; if (xlog[b] !== 8'h00)   begin bad++; $display("FAIL b2b_byte0 got=%h want=00", xlog[b]); end
        total++; if (xlog[b+1] !== 8'hFF) begin bad++; $display("FAIL b2b_byte1 got=%h want=ff", xlog[b+1]); end
        total++; if (xlog[b+2] !== 8'h3C) begin bad++; $display("FAIL b2b_byte2 got=%h want=3c", xlog[b+2]); end
        total++; if (fe_cnt != fb)       begin bad++; $display("FAIL b2b_fe got=%0d want=0", fe_cnt - fb); end
        total++; if (ov_cnt != ob)       begin bad++; $display("FAIL b2b_ov got=%0d want=0", ov_cnt - ob); end
    endtask

    task automatic test_glitch();
        int b, fb;
        b = xcnt; fb = fe_cnt;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(30);
        total++; if (xcnt != b)   begin bad++; $display("FAIL glitch_output got=%0d want=0", xcnt - b); end
        total++; if (fe_cnt != fb) begin bad++; $display("FAIL glitch_fe got=%0d want=0", fe_cnt - fb); end
        send_frame(8'h81, 1'b1);
        tick(20);
        total++; if (xcnt - b != 1)    begin bad++; $display("FAIL glitch_next_count got=%0d want=1", xcnt - b); end
        total++; if (xlog[b] !== 8'h81) begin bad++; $display("FAIL glitch_next_data got=%h want=81", xlog[b]); end
    endtask

    task automatic test_framing();
        int b, fb, ob;
        b = xcnt; fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h55, 1'b0);
        tick(30);
        serial_in = 1'b1;
        tick(12);
        send_frame(8'h12, 1'b1);
        tick(20);
        total++; if (fe_cnt - fb != 1) begin bad++; $display("FAIL frame_fe got=%0d want=1", fe_cnt - fb); end
        total++; if (xcnt - b != 1)    begin bad++; $display("FAIL frame_count got=%0d want=1", xcnt - b); end
        total++; if (xlog[b] !== 8'h12) begin bad++; $display("FAIL frame_data got=%h want=12", xlog[b]); end
        total++; if (ov_cnt != ob)     begin bad++; $display("FAIL frame_ov got=%0d want=0", ov_cnt - ob); end
    endtask

    task automatic test_overrun();
        int b, fb, ob;
        data_out_ready = 1'b0;
        b = xcnt; fb = fe_cnt; ob = ov_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        total++; if (ov_cnt - ob != 1)       begin bad++; $display("FAIL ovr_pulse got=%0d want=1", ov_cnt - ob); end
        total++; if (data_out !== 8'h11)      begin bad++; $display("FAIL ovr_kept got=%h want=11", data_out); end
        total++; if (data_out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", data_out_valid); end
        total++; if (fe_cnt != fb)           begin bad++; $display("FAIL ovr_fe got=%0d want=0", fe_cnt - fb); end
        data_out_ready = 1'b1;
        tick(5);
        total++; if (xcnt - b != 1)           begin bad++; $display("FAIL ovr_xfer_count got=%0d want=1", xcnt - b); end
        total++; if (xlog[b] !== 8'h11)        begin bad++; $display("FAIL ovr_xfer_data got=%h want=11", xlog[b]); end
        total++; if (data_out_valid !== 1'b0) begin bad++; $display("FAIL ovr_drained got=%b want=0", data_out_valid); end
    endtask

    task automatic test_reset_mid_frame();
        int b;
        logic [7:0] v;
        v = 8'h77;
        data_out_ready = 1'b1;
        b = xcnt;
        serial_in = 1'b0;
        tick(SYM);
        for (int i = 0; i < 4; i++) begin
            serial_in = v[i];
            tick(SYM);
        end
        // Halfway through bit 4 (a 1); the sender abandons the frame too
        serial_in = v[4];
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        serial_in = 1'b1;
        tick(40);
        total++; if (xcnt != b) begin bad++; $display("FAIL midrst_output got=%0d want=0", xcnt - b); end
        send_frame(8'h42, 1'b1);
        tick(20);
        total++; if (xcnt - b != 1)    begin bad++; $display("FAIL midrst_count got=%0d want=1", xcnt - b); end
        total++; if (xlog[b] !== 8'h42) begin bad++; $display("FAIL midrst_data got=%h want=42", xlog[b]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
